alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 12-bit ALU datapath (ADD/SUB/AND/OR/XOR/NOT/CLR, 4-bit FUNC) between NUM_REQ requesters. It accepts one operation per grant, drives the ALU from registered operands, and captures OUT/OF/CARRY. It returns the result tagged with the requester id over a valid/ready response channel. The block sits between the requester-side command buses and the combinational ALU instance.

---
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one requester at a time onto a shared 12-bit ALU and returns the tagged result.
// Build option ALU_ARB_RR_EN selects round-robin grants; otherwise the lowest index wins.
module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]      req_func,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [3:0]                alu_func,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_of,
   input  logic                      alu_carry,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_of,
   output logic                      rsp_carry,
   output logic                      rsp_err,
   output logic                      busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_any;
   logic [ID_W-1:0]     w_gnt_id;
   logic [NUM_REQ-1:0]  w_ready;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [3:0]          r_alu_func;
   logic [ID_W-1:0]     r_id;
   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_rsp_of;
   logic                r_rsp_carry;
   logic                r_rsp_err;
`ifdef ALU_ARB_RR_EN
   logic [ID_W-1:0]     r_ptr;
   int                  w_idx;
`endif

   function automatic logic f_func_ok(input logic [3:0] func);
      case (func)
         4'b0001, 4'b0010, 4'b0100, 4'b0101,
         4'b0110, 4'b1000, 4'b1001: f_func_ok = 1'b1;
         default:                   f_func_ok = 1'b0;
      endcase
   endfunction

   // Grant selection: scan downward so the candidate nearest the search start wins
   always_comb begin
      w_any    = 1'b0;
      w_gnt_id = '0;
`ifdef ALU_ARB_RR_EN
      w_idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx    = (int'(r_ptr) + k >= NUM_REQ) ? (int'(r_ptr) + k - NUM_REQ) : (int'(r_ptr) + k);
         w_gnt_id = req_valid[w_idx] ? ID_W'(w_idx) : w_gnt_id;
         w_any    = w_any | req_valid[w_idx];
      end
`else
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_gnt_id = req_valid[k] ? ID_W'(k) : w_gnt_id;
         w_any    = w_any | req_valid[k];
      end
`endif
   end

   // Next-state and combinational accept
   always_comb begin
      w_next_state = r_state;
      w_ready      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any && !rst) begin
               w_next_state      = ST_EXEC;
               w_ready[w_gnt_id] = 1'b1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: w_next_state = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand capture, result capture and response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_func  <= 4'b0000;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_of    <= 1'b0;
         r_rsp_carry <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_alu_a    <= req_a[int'(w_gnt_id) * DATA_W +: DATA_W];
                  r_alu_b    <= req_b[int'(w_gnt_id) * DATA_W +: DATA_W];
                  r_alu_func <= req_func[int'(w_gnt_id) * 4 +: 4];
                  r_id       <= w_gnt_id;
               end
            end
            ST_EXEC: begin
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
               // Unsupported codes leave the ALU output undriven; never let it through
               if (f_func_ok(r_alu_func)) begin
                  r_rsp_data  <= alu_out;
                  r_rsp_of    <= alu_of;
                  r_rsp_carry <= alu_carry;
                  r_rsp_err   <= 1'b0;
               end else begin
                  r_rsp_data  <= '0;
                  r_rsp_of    <= 1'b0;
                  r_rsp_carry <= 1'b0;
                  r_rsp_err   <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_ARB_RR_EN
   // Round-robin pointer moves just past each granted requester
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_state == ST_IDLE && w_any) begin
         r_ptr <= (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + ID_W'(1);
      end else begin
         r_ptr <= r_ptr;
      end
   end
`endif

   assign req_ready = w_ready;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_func  = r_alu_func;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_of    = r_rsp_of;
   assign rsp_carry = r_rsp_carry;
   assign rsp_err   = r_rsp_err;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction model plus directed vectors with literal expectations.
module tb_alu_arbiter;
   localparam int N = 4;
   localparam int W = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N*4-1:0] req_func = '0;
   logic           rsp_ready = 1'b1;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   alu_a, alu_b, alu_out;
   logic [3:0]     alu_func;
   logic           alu_of, alu_carry;
   logic           rsp_valid, rsp_of, rsp_carry, rsp_err, busy;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic [14:0]    alu_res;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_func(req_func),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_out(alu_out), .alu_of(alu_of), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_of(rsp_of), .rsp_carry(rsp_carry),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // {supported, of, carry, out}; unsupported codes return junk so leaks are visible
   function automatic logic [14:0] alu_ref(input logic [11:0] a, input logic [11:0] b, input logic [3:0] f);
      logic [12:0] s;
      logic [14:0] r;
      case (f)
         4'b0001: begin
            s = {1'b0, a} + {1'b0, b};
            r = {1'b1, (a[11] == b[11]) && (s[11] != a[11]), s[12], s[11:0]};
         end
         4'b0010: begin
            s = {1'b0, a} - {1'b0, b};
            r = {1'b1, (a[11] != b[11]) && (s[11] != a[11]), s[12], s[11:0]};
         end
         4'b0100: r = {3'b100, a & b};
         4'b0101: r = {3'b100, a | b};
         4'b0110: r = {3'b100, a ^ b};
         4'b1000: r = {3'b100, ~a};
         4'b1001: r = {3'b100, 12'h000};
         default: r = {3'b011, 12'hABC};
      endcase
      return r;
   endfunction

   assign alu_res = alu_ref(alu_a, alu_b, alu_func);
   assign {alu_of, alu_carry, alu_out} = alu_res[13:0];

   function automatic int arb(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: 0 = waiting for a command, 1 = computing, 2 = offering response
   int          m_stage = 0;
   int          m_ptr = 0;
   int          m_id = 0;
   bit          m_started = 1'b0;
   logic [11:0] m_a = '0, m_b = '0, m_data = '0;
   logic [3:0]  m_f = '0;
   logic [1:0]  m_rid = '0;
   logic        m_valid = 1'b0, m_err = 1'b0, m_of = 1'b0, m_carry = 1'b0;
   logic [14:0] m_res;

   assign m_res = alu_ref(m_a, m_b, m_f);

   always @(posedge clk) begin
      if (rst) begin
         m_started <= 1'b1;
         m_stage <= 0; m_ptr <= 0;
         m_a <= '0; m_b <= '0; m_f <= '0;
         m_valid <= 1'b0; m_err <= 1'b0; m_data <= '0; m_of <= 1'b0; m_carry <= 1'b0; m_rid <= '0;
      end else if (m_stage == 0) begin
         if (|req_valid) begin
            m_a  <= req_a[arb(req_valid, m_ptr) * W +: W];
            m_b  <= req_b[arb(req_valid, m_ptr) * W +: W];
            m_f  <= req_func[arb(req_valid, m_ptr) * 4 +: 4];
            m_id <= arb(req_valid, m_ptr);
`ifdef ALU_ARB_RR_EN
            m_ptr <= (arb(req_valid, m_ptr) + 1) % N;
`endif
            m_stage <= 1;
         end
      end else if (m_stage == 1) begin
         m_rid   <= 2'(m_id);
         m_valid <= 1'b1;
         m_stage <= 2;
         m_err   <= ~m_res[14];
         m_of    <= m_res[14] & m_res[13];
         m_carry <= m_res[14] & m_res[12];
         m_data  <= m_res[14] ? m_res[11:0] : 12'h000;
      end else begin
         if (rsp_ready) begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_stage <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("req_ready", req_ready,
             (m_stage == 0 && !rst && |req_valid) ? (4'b0001 << arb(req_valid, m_ptr)) : 4'b0000);
         chk("busy", busy, m_stage != 0);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_func", alu_func, m_f);
         chk("rsp_valid", rsp_valid, m_valid);
         chk("rsp_err", rsp_err, m_err);
         chk("rsp_id", rsp_id, m_rid);
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_of", rsp_of, m_of);
         chk("rsp_carry", rsp_carry, m_carry);
      end
   end

   task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b, input logic [3:0] f);
      req_a[i * W +: W]  = a;
      req_b[i * W +: W]  = b;
      req_func[i * 4 +: 4] = f;
      req_valid[i] = 1'b1;
   endtask

   // Present a command, wait for its accept, then withdraw it just after the grant edge
   task automatic issue(input int i, input logic [11:0] a, input logic [11:0] b, input logic [3:0] f);
      int n;
      n = 0;
      set_req(i, a, b, f);
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[i] && n < 40);
      chk("grant_seen", req_ready[i], 1'b1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || rsp_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

`ifdef ALU_ARB_RR_EN
   localparam int NG = 5;
   int exp_order[NG] = '{0, 1, 2, 3, 0};
`else
   localparam int NG = 3;
   int exp_order[NG] = '{0, 0, 0};
`endif

   initial begin
      int idx;
      int n;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_alu_a", alu_a, 12'h000);
      chk("rst_req_ready", req_ready, 4'b0000);

      // Single ADD from requester 0
      @(posedge clk);
      #1 set_req(0, 12'h0FF, 12'h001, 4'b0001);
      @(negedge clk);
      chk("add_ready_same_cycle", req_ready, 4'b0001);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      chk("add_not_yet_valid", rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("add_rsp_valid", rsp_valid, 1'b1);
      chk("add_rsp_id", rsp_id, 2'd0);
      chk("add_rsp_data", rsp_data, 12'h100);
      chk("add_rsp_err", rsp_err, 1'b0);
      wait_idle();

      // Backpressure on a SUB while requester 3 waits
      rsp_ready = 1'b0;
      issue(1, 12'h005, 12'h007, 4'b0010);
      set_req(3, 12'h0F0, 12'h0FF, 4'b0110);
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_data", rsp_data, 12'hFFE);
         chk("bp_carry", rsp_carry, 1'b1);
         chk("bp_ready_zero", req_ready, 4'b0000);
         chk("bp_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_busy", busy, 1'b0);
      chk("bp_release_grant3", req_ready, 4'b1000);
      @(posedge clk);
      #1 req_valid[3] = 1'b0;
      wait_idle();

      // Unsupported FUNC
      issue(0, 12'h123, 12'h456, 4'b0011);
      @(posedge clk);
      @(negedge clk);
      chk("inv_err", rsp_err, 1'b1);
      chk("inv_data", rsp_data, 12'h000);
      chk("inv_of", rsp_of, 1'b0);
      chk("inv_carry", rsp_carry, 1'b0);
      wait_idle();

      // NOT then CLR from requester 2
      issue(2, 12'hF0F, 12'h000, 4'b1000);
      @(posedge clk);
      @(negedge clk);
      chk("not_data", rsp_data, 12'h0F0);
      chk("not_id", rsp_id, 2'd2);
      wait_idle();
      issue(2, 12'h5A5, 12'h3C3, 4'b1001);
      @(posedge clk);
      @(negedge clk);
      chk("clr_data", rsp_data, 12'h000);
      chk("clr_id", rsp_id, 2'd2);
      wait_idle();

      // Reset while the op is executing
      issue(1, 12'h00F, 12'h001, 4'b0001);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rexec_valid", rsp_valid, 1'b0);
      chk("rexec_busy", busy, 1'b0);
      chk("rexec_alu_a", alu_a, 12'h000);
      chk("rexec_alu_func", alu_func, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rexec_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // All requesters valid continuously
      for (int i = 0; i < N; i++) set_req(i, 12'(i + 1), 12'(i * 16), 4'b0001);
      for (int g = 0; g < NG; g++) begin
         idx = -1;
         n = 0;
         while (req_ready == 4'b0000 && n < 40) begin
            @(negedge clk);
            n++;
         end
         for (int k = 0; k < N; k++) begin
            if (req_ready[k]) idx = k;
         end
         chk("grant_order", idx, exp_order[g]);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
